// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss-handling engine that sits between an L1 cache (I-side or D-side) and
// the multi-cycle main memory. When a miss is accepted, it stalls the
// pipeline and streams one cache block from memory as pipelined word reads.
// Reads are issued back to back, one per cycle. Each returned word is written
// into the data array in the same cycle it arrives. The tag array is written
// together with the last word, which makes the block valid only once it is
// complete.
//
// Parameters
//   WORDS_PER_BLOCK  16-bit words per block (power of two, >= 2)
//   MEM_LATENCY      cycles from a read issue to its memory_data_valid
//                    (informational; responses are counted, not timed)
//
// Ports
//   clk                 in   system clock, rising edge
//   rst                 in   synchronous active-high reset
//   miss_detected       in   cache lookup missed this cycle
//   miss_address[15:0]  in   byte address of the missing access
//   memory_data_valid   in   memory_data holds a returned word
//   memory_data[15:0]   in   returned word
//   fsm_busy            out  fill in progress, pipeline must stall
//   mem_read_en         out  issue a read of memory_address this cycle
//   memory_address      out  byte address sent to main memory
//   write_data_array    out  write cache_write_data at cache_write_address
//   write_tag_array     out  write tag/valid of the filled block (1 cycle)
//   cache_write_address out  byte address of the word being written
//   cache_write_data    out  word being written (memory_data)
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] cache_write_address,
    output logic [15:0] cache_write_data
);

    // IW : bits of word index inside a block
    // OFS: byte-offset bits of a block (word index + byte-in-word bit)
    // BW : width of the block base (address bits above the offset)
    localparam int IW  = $clog2(WORDS_PER_BLOCK);
    localparam int OFS = IW + 1;
    localparam int BW  = 16 - OFS;

    // Elaboration-time parameter sanity checks.
    if ((WORDS_PER_BLOCK < 2) ||
        ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0)) begin : g_bad_wpb
        $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of two >= 2");
    end
    if (MEM_LATENCY < 1) begin : g_bad_lat
        $error("cache_fill_fsm: MEM_LATENCY must be >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    state_e          state_q;
    // Only the block-aligned upper address bits are stored. Every word address
    // is formed by concatenation, so the base can never carry (0xFFF0 block
    // ends at 0xFFFE).
    logic [BW-1:0]   base_q;
    // issue_cnt needs one extra bit to represent "all words issued".
    logic [IW:0]     issue_cnt_q;
    logic [IW-1:0]   recv_cnt_q;

    logic            active;
    logic            issue_done;
    logic            last_word;
    logic [IW-1:0]   issue_idx;
    logic [BW-1:0]   miss_base;

    assign miss_base  = miss_address[15:OFS];
    assign issue_done = issue_cnt_q[IW];
    assign last_word  = &recv_cnt_q;

    // After the last issue the address bus parks on the final word of the block.
    assign issue_idx  = issue_done ? {IW{1'b1}} : issue_cnt_q[IW-1:0];

    // ------------------------------------------------------------------
    // State, counters and latched block base
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Stray memory_data_valid in IDLE is deliberately ignored.
                    if (miss_detected) begin
                        state_q     <= FILL;
                        base_q      <= miss_base;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end
                end
                FILL: begin
                    // A held miss_detected is ignored here. The requester
                    // re-looks-up once fsm_busy drops.
                    if (!issue_done) begin
                        issue_cnt_q <= issue_cnt_q + (IW+1)'(1);
                    end
                    if (memory_data_valid) begin
                        recv_cnt_q <= recv_cnt_q + IW'(1);
                        if (last_word) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state. The data path follows
    // memory_data_valid in the same cycle. Everything is forced low while
    // rst is high, so an abort is visible without waiting for the edge.
    // ------------------------------------------------------------------
    assign active = (state_q == FILL) && !rst;

    always_comb begin
        fsm_busy            = active;
        mem_read_en         = active && !issue_done;
        memory_address      = '0;
        write_data_array    = active && memory_data_valid;
        write_tag_array     = active && memory_data_valid && last_word;
        cache_write_address = '0;
        cache_write_data    = '0;
        if (active) begin
            memory_address = {base_q, issue_idx, 1'b0};
        end
        if (active && memory_data_valid) begin
            cache_write_address = {base_q, recv_cnt_q, 1'b0};
            cache_write_data    = memory_data;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm. Two instances are driven: u0 with the default
// geometry (8 words, latency 4) and u1 with 4 words, latency 2.
// A fixed-latency memory model answers every read.
// The reference model is a per-fill cycle timer. Cycle t after acceptance
// issues word t-1, writes word t-L-1, and tags on cycle L+W.
module tb_cache_fill_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        miss [2];
    logic [15:0] maddr [2];
    logic        mdv [2];
    logic [15:0] mdata [2];
    logic        stray [2];
    logic        o_busy [2];
    logic        o_mre [2];
    logic [15:0] o_ma [2];
    logic        o_wda [2];
    logic        o_wta [2];
    logic [15:0] o_cwa [2];
    logic [15:0] o_cwd [2];

    cache_fill_fsm #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) u0 (
        .clk(clk), .rst(rst),
        .miss_detected(miss[0]), .miss_address(maddr[0]),
        .memory_data_valid(mdv[0]), .memory_data(mdata[0]),
        .fsm_busy(o_busy[0]), .mem_read_en(o_mre[0]), .memory_address(o_ma[0]),
        .write_data_array(o_wda[0]), .write_tag_array(o_wta[0]),
        .cache_write_address(o_cwa[0]), .cache_write_data(o_cwd[0])
    );

    cache_fill_fsm #(.WORDS_PER_BLOCK(4), .MEM_LATENCY(2)) u1 (
        .clk(clk), .rst(rst),
        .miss_detected(miss[1]), .miss_address(maddr[1]),
        .memory_data_valid(mdv[1]), .memory_data(mdata[1]),
        .fsm_busy(o_busy[1]), .mem_read_en(o_mre[1]), .memory_address(o_ma[1]),
        .write_data_array(o_wda[1]), .write_tag_array(o_wta[1]),
        .cache_write_address(o_cwa[1]), .cache_write_data(o_cwd[1])
    );

    // ---------------- main memory model ----------------
    logic [15:0] mem [32768];
    logic [7:0]  pv0 = '0;
    logic [7:0]  pv1 = '0;
    logic [15:0] pa0 [8];
    logic [15:0] pa1 [8];

    always @(posedge clk) begin
        pv0 <= {pv0[6:0], o_mre[0]};
        pv1 <= {pv1[6:0], o_mre[1]};
        pa0[0] <= o_ma[0];
        pa1[0] <= o_ma[1];
        for (int i = 1; i < 8; i++) begin
            pa0[i] <= pa0[i-1];
            pa1[i] <= pa1[i-1];
        end
    end

    assign mdv[0]   = pv0[3] | stray[0];
    assign mdata[0] = mem[pa0[3][15:1]];
    assign mdv[1]   = pv1[1] | stray[1];
    assign mdata[1] = mem[pa1[1][15:1]];

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    localparam int WPB [2] = '{8, 4};
    localparam int LAT [2] = '{4, 2};
    bit          m_busy [2];
    int          m_t [2];
    logic [15:0] m_base [2];
    int          quiet [2];
    int          n_tags [2];

    // drive requests for the next step
    bit          d_rst;
    bit          d_miss [2];
    logic [15:0] d_addr [2];
    bit          d_stray [2];

    task automatic step();
        int w;
        int l;
        int k;
        logic        eb, emr, ewd, etg;
        logic [15:0] ema, ecwa, ecwd;
        bit          acc;
        @(negedge clk);
        cyc++;
        for (int u = 0; u < 2; u++) begin
            w = WPB[u];
            l = LAT[u];
            eb = 0; emr = 0; ewd = 0; etg = 0;
            ema = '0; ecwa = '0; ecwd = '0;
            if (!rst && m_busy[u]) begin
                eb  = 1;
                emr = (m_t[u] <= w);
                k   = (m_t[u] <= w) ? m_t[u] - 1 : w - 1;
                ema = m_base[u] + 16'(2 * k);
                if (m_t[u] > l) begin
                    ewd  = 1;
                    ecwa = m_base[u] + 16'(2 * (m_t[u] - l - 1));
                    ecwd = mem[ecwa[15:1]];
                    etg  = (m_t[u] == l + w);
                end
            end
            if (o_wta[u] === 1'b1) n_tags[u]++;
            chk($sformatf("u%0d fsm_busy", u), 32'(o_busy[u]), 32'(eb));
            chk($sformatf("u%0d mem_read_en", u), 32'(o_mre[u]), 32'(emr));
            chk($sformatf("u%0d memory_address", u), 32'(o_ma[u]), 32'(ema));
            chk($sformatf("u%0d write_data_array", u), 32'(o_wda[u]), 32'(ewd));
            chk($sformatf("u%0d write_tag_array", u), 32'(o_wta[u]), 32'(etg));
            chk($sformatf("u%0d cache_write_address", u), 32'(o_cwa[u]), 32'(ecwa));
            chk($sformatf("u%0d cache_write_data", u), 32'(o_cwd[u]), 32'(ecwd));
        end
        // apply next inputs and advance the model to the next cycle
        rst = d_rst;
        for (int u = 0; u < 2; u++) begin
            acc = d_miss[u] && (quiet[u] == 0);
            miss[u]  = acc;
            maddr[u] = d_addr[u];
            if (d_rst) begin
                m_busy[u] = 0;
                quiet[u]  = 12;   // let aborted responses drain
            end else if (!m_busy[u]) begin
                if (quiet[u] > 0) quiet[u]--;
                if (acc) begin
                    m_busy[u] = 1;
                    m_t[u]    = 1;
                    m_base[u] = d_addr[u] & ~16'(2 * WPB[u] - 1);
                end
            end else if (m_t[u] == LAT[u] + WPB[u]) begin
                m_busy[u] = 0;
            end else begin
                m_t[u]++;
            end
            stray[u] = d_stray[u] && !m_busy[u];
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        d_rst = 0;
        for (int u = 0; u < 2; u++) begin
            d_miss[u]  = 0;
            d_stray[u] = 0;
        end
    endtask

    initial begin
        int tags_before;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        rst = 1;
        for (int u = 0; u < 2; u++) begin
            miss[u] = 0; maddr[u] = '0; stray[u] = 0;
            m_busy[u] = 0; m_t[u] = 0; m_base[u] = '0; quiet[u] = 0; n_tags[u] = 0;
            d_addr[u] = '0;
        end
        clr();
        d_rst = 1;
        repeat (2) @(posedge clk);
        run(2);                         // outputs held at 0 in reset
        clr();
        run(2);                         // idle after reset

        // single fills: 0x1234 on u0, 0x0108 on u1 (4-word / latency-2)
        d_miss[0] = 1; d_addr[0] = 16'h1234;
        d_miss[1] = 1; d_addr[1] = 16'h0108;
        step();
        clr();
        run(16);

        // back-to-back: 0x0040 accepted, then 0x2000 held until accepted
        d_miss[0] = 1; d_addr[0] = 16'h0040;
        step();
        d_addr[0] = 16'h2000;
        for (int i = 0; i < 40 && !(m_busy[0] && m_t[0] == 1 && m_base[0] == 16'h2000); i++)
            step();
        chk("u0 second fill accepted", 32'(m_base[0]), 32'h2000);
        clr();
        run(16);

        // reset mid-fill, late responses must be ignored
        d_miss[0] = 1; d_addr[0] = 16'h5678;
        d_miss[1] = 1; d_addr[1] = 16'h0A0A;
        step();
        clr();
        run(5);
        tags_before = n_tags[0];
        d_rst = 1;
        step();
        clr();
        run(14);
        chk("u0 no tag after abort", 32'(n_tags[0]), 32'(tags_before));

        // stray valid pulses in IDLE
        for (int i = 0; i < 12; i++) begin
            d_stray[0] = 1'($urandom);
            d_stray[1] = 1'($urandom);
            step();
        end
        clr();
        run(2);

        // top-of-memory block, no wrap, one tag
        tags_before = n_tags[0];
        d_miss[0] = 1; d_addr[0] = 16'hFFFF;
        d_miss[1] = 1; d_addr[1] = 16'hFFFF;
        step();
        clr();
        run(16);
        chk("u0 single tag at 0xFFF0", 32'(n_tags[0] - tags_before), 32'd1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            d_rst = ($urandom_range(0, 99) == 0);
            for (int u = 0; u < 2; u++) begin
                if (!d_miss[u] || $urandom_range(0, 3) == 0) begin
                    d_miss[u] = ($urandom_range(0, 3) == 0);
                    d_addr[u] = 16'($urandom);
                end
                d_stray[u] = ($urandom_range(0, 4) == 0);
            end
            step();
        end
        clr();
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
